// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC holder and imem fetcher with redirect and instruction buffer; optional FETCH_ALIGN_CHECK_EN
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        instr_exc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      mem_instr_q [FIFO_DEPTH];
  logic [31:0]      mem_pc_q    [FIFO_DEPTH];
  logic [31:0]      mem_pc4_q   [FIFO_DEPTH];
  logic             push, pop, flush;
  logic [31:0]      push_instr, push_pc, push_pc4;
  logic [CNT_W-1:0] count_after;

`ifdef FETCH_ALIGN_CHECK_EN
  logic             mem_exc_q [FIFO_DEPTH];
  logic             push_exc;
  logic             halt_q, halt_d;
  logic             misaligned;
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign imem_addr  = fetch_pc_q;
  assign instr_exc  = mem_exc_q[rd_ptr_q];
`else
  assign imem_addr  = {fetch_pc_q[31:2], 2'b00};
  assign instr_exc  = 1'b0;
`endif

  assign instr_valid = (count_q != '0);
  assign instr       = mem_instr_q[rd_ptr_q];
  assign instr_pc    = mem_pc_q[rd_ptr_q];
  assign instr_pc4   = mem_pc4_q[rd_ptr_q];
  assign pop         = instr_valid && instr_ready;
  assign flush       = redirect_valid;
  // count after this cycle's response push and decode pop, used to decide whether to keep fetching
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

  // next-state, fetch PC and push selection; redirect overrides the normal flow last
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    push_instr = imem_rdata;
    push_pc    = fetch_pc_q - 32'd4;  // fetch_pc already advanced past the in-flight word
    push_pc4   = fetch_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    push_exc   = 1'b0;
    halt_d     = halt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
        if ((count_q < DEPTH_C) && !halt_q) state_d = S_REQ;
`else
        if (count_q < DEPTH_C) state_d = S_REQ;
`endif
      end
      S_REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (misaligned) begin
          if (count_q < DEPTH_C) begin
            push       = 1'b1;
            push_instr = 32'd0;
            push_pc    = fetch_pc_q;
            push_pc4   = fetch_pc_q + 32'd4;
            push_exc   = 1'b1;
            halt_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
`else
        imem_req = 1'b1;
        if (imem_gnt) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
`endif
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      push       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_d     = 1'b0;
`endif
      case (state_q)
        S_REQ:   state_d = (imem_req && imem_gnt) ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM and architectural fetch PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_q     <= halt_d;
`endif
    end
  end

  // instruction buffer: registered storage, flushed on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
        mem_pc4_q[i]   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_exc_q[i]   <= 1'b0;
`endif
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_instr_q[wr_ptr_q] <= push_instr;
        mem_pc_q[wr_ptr_q]    <= push_pc;
        mem_pc4_q[wr_ptr_q]   <= push_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_exc_q[wr_ptr_q]   <= push_exc;
`endif
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_exc;
  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc4(instr_pc4), .instr_exc(instr_exc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (3) step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL reset_addr: got %h expected 00003000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
    checks++; if (instr_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 0", instr_pc4); end
    checks++; if (instr_exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", instr_exc); end
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00003000", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3C01_1234;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL first_wait_req: got %b expected 0", imem_req); end
    step();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h3C01_1234) begin errors++; $display("FAIL first_instr: got v=%b %h expected v=1 3c011234", instr_valid, instr); end
    checks++; if (instr_pc !== 32'h3000 || instr_pc4 !== 32'h3004) begin errors++; $display("FAIL first_pc: got %h/%h expected 00003000/00003004", instr_pc, instr_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL second_req: got req=%b addr=%h expected req=1 addr=00003004", imem_req, imem_addr); end
  endtask

  task automatic test_backpressure();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2001_0004;
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_%0d: got %b expected 0", i, imem_req); end
      step();
    end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h3000) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=00003000", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h2001_0004 || instr_pc !== 32'h3004 || instr_pc4 !== 32'h3008) begin
      errors++; $display("FAIL bp_second: got v=%b %h pc=%h pc4=%h expected v=1 20010004 00003004 00003008", instr_valid, instr, instr_pc, instr_pc4);
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_still_idle: got %b expected 0", imem_req); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin errors++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=00003008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3040;
    step();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_req: got %b expected 0", imem_req); end
    step();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_visible: got v=%b pc=%h expected v=0", instr_valid, instr_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin errors++; $display("FAIL rw_reissue: got req=%b addr=%h expected req=1 addr=00003040", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_req();
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_3040;
    step();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h3040) begin errors++; $display("FAIL rr_buffered: got v=%b pc=%h expected v=1 pc=00003040", instr_valid, instr_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin errors++; $display("FAIL rr_addr: got req=%b addr=%h expected req=1 addr=00003100", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rr_flush: got %b expected 0", instr_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0FFC;
    step();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc: got v=%b pc=%h pc4=%h expected v=1 fffffffc 00000000", instr_valid, instr_pc, instr_pc4);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_pc = 32'h4000; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b_req_%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 32'h4000 + 32'(4 * i));
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA0 + 32'(i);
      step();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hA0 + 32'(i) || instr_pc !== 32'h4000 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b_out_%0d: got v=%b %h pc=%h expected v=1 %h pc=%h", i, instr_valid, instr, instr_pc, 32'hA0 + 32'(i), 32'h4000 + 32'(4 * i));
      end
    end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    redirect_valid = 1'b1; redirect_pc = 32'h3002; instr_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL al_noreq0: got %b expected 0", imem_req); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_exc !== 1'b1 || instr_pc !== 32'h3002 || instr !== 32'h0) begin
      errors++; $display("FAIL al_exc: got v=%b exc=%b pc=%h instr=%h expected v=1 exc=1 00003002 0", instr_valid, instr_exc, instr_pc, instr);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL al_halt_%0d: got %b expected 0", i, imem_req); end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h3010;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL al_resume: got req=%b addr=%h v=%b expected req=1 addr=00003010 v=0", imem_req, imem_addr, instr_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_wrap();
    test_back_to_back();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer side of next-PC selection: holds the architectural PC and fetches instructions from instruction memory over a req/gnt/rvalid handshake.
- Buffers fetched words in a small FIFO toward decode.
- Takes redirects (branch, jr, jal targets) and discards wrong-path words.
- Sits between the next-PC logic / imem port and the decode stage of the pipelined CPU.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: taken branch/jump
- redirect_pc  in  32  redirect target
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction word
- instr_pc  out  32  head PC
- instr_pc4  out  32  head PC+4
- instr_exc  out  1  head fetch-address exception (feature only; else 0)

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr/instr_pc/instr_pc4=0, instr_exc=0.
- At most one outstanding request.
- Credit: issue only if FIFO count + in-flight < FIFO_DEPTH.
- States:
  - IDLE: imem_req=0. Go to REQ when credit is available.
  - REQ: imem_req=1, imem_addr=fetch_pc, held stable until gnt. On gnt: fetch_pc+=4, go to WAIT.
  - WAIT: on rvalid, push {imem_rdata, pc, pc+4}. Then go to REQ if credit remains, else IDLE.
  - DROP: a stale response is pending. On rvalid, discard the word. Then go to REQ at the redirected fetch_pc.
- Redirect, priority over everything else, takes effect on the edge where redirect_valid=1:
  - FIFO flushed; fetch_pc=redirect_pc.
  - In REQ without gnt: the request is withdrawn. Next cycle it reissues at redirect_pc.
  - In REQ with gnt in the same cycle: the granted request is stale; go to DROP.
  - In WAIT without rvalid: go to DROP.
  - In WAIT with rvalid in the same cycle: the word is discarded; go to REQ.
  - In DROP: stay in DROP; fetch_pc is updated.
  - In IDLE: go to REQ.
- FIFO:
  - Push on accepted response, pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head outputs come from registers; no imem_rdata→instr combinational path.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- Throughput: with 1-cycle rvalid latency and decode always ready, one instruction every 2 cycles.
- instr_valid rises 1 cycle after rvalid. It drops the cycle after a redirect.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Enabled:
  - If fetch_pc[1:0]≠0, no imem request is issued.
  - A single FIFO entry is pushed with instr=0, instr_exc=1, instr_pc=the bad PC.
  - Fetching then halts in IDLE until the next redirect.
- Disabled:
  - imem_addr = {fetch_pc[31:2],2'b00}.
  - instr_exc tied 0.

Test Plan:
- Reset/first fetch:
  - Release rst_n; gnt same cycle, rvalid next cycle with rdata=32'h3C01_1234.
  - Expect imem_addr=0x3000, then instr_valid with instr=32'h3C01_1234, instr_pc=0x3000, instr_pc4=0x3004.
- Backpressure:
  - Hold instr_ready=0.
  - Exactly 2 words buffered (0x3000, 0x3004); imem_req stays 0.
  - Release: words delivered in order, fetch resumes at 0x3008.
- Redirect in WAIT:
  - Redirect to 0x3040 while the 0x3008 response is outstanding.
  - The stale rvalid word is discarded; next imem_addr=0x3040.
  - No 0x3008 instruction appears at the output.
- Redirect in REQ before gnt:
  - imem_gnt=0, redirect_pc=0x0000_3100.
  - Next-cycle imem_addr=0x3100; FIFO empties.
- Wrap:
  - Redirect to 32'hFFFF_FFFC, deliver the word.
  - Expect instr_pc4=0 and next imem_addr=0.
- FETCH_ALIGN_CHECK_EN:
  - Redirect to 0x3002.
  - Expect no imem_req; instr_valid with instr_exc=1, instr_pc=0x3002.
  - A redirect to 0x3010 resumes fetch.
